// File: rtl/cpu_bus_pkg.sv
// Shared bus constants: resolution modes, default geometry and the datapath's
// source ordering, so that src_oe bit positions have names.
package cpu_bus_pkg;

  localparam int BUS_MODE_REJECT   = 0;
  localparam int BUS_MODE_PRIORITY = 1;

  localparam int DATA_W_DEFAULT = 32;
  localparam int N_SRC_DEFAULT  = 24;

  localparam int SRC_R0     = 0;
  localparam int SRC_R1     = 1;
  localparam int SRC_R2     = 2;
  localparam int SRC_R3     = 3;
  localparam int SRC_R4     = 4;
  localparam int SRC_R5     = 5;
  localparam int SRC_R6     = 6;
  localparam int SRC_R7     = 7;
  localparam int SRC_R8     = 8;
  localparam int SRC_R9     = 9;
  localparam int SRC_R10    = 10;
  localparam int SRC_R11    = 11;
  localparam int SRC_R12    = 12;
  localparam int SRC_R13    = 13;
  localparam int SRC_R14    = 14;
  localparam int SRC_R15    = 15;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHIGH  = 18;
  localparam int SRC_ZLOW   = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_CSIGN  = 23;

endpackage

// File: rtl/onehot_enc_chk.sv
// Combinational encoder for an output-enable vector: returns the lowest set
// index, whether any bit is set, and whether more than one bit is set.
module onehot_enc_chk #(
  parameter int N     = 24,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     vec,
  output logic [SEL_W-1:0] idx,
  output logic             any,
  output logic             multi
);

  // Scan downwards so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = SEL_W'(i);
    end
  end

  assign any   = |vec;
  assign multi = |(vec & (vec - N'(1)));

endmodule

// File: rtl/pipelined_bus_mux.sv
// Registered N_SRC-way bus mux with multi-driver detection, bus-hold stall,
// a sticky error flag and a saturating conflict counter.
module pipelined_bus_mux
  import cpu_bus_pkg::*;
#(
  parameter int N_SRC         = N_SRC_DEFAULT,
  parameter int DATA_W        = DATA_W_DEFAULT,
  parameter int SEL_W         = $clog2(N_SRC),
  parameter int PRIORITY_MODE = BUS_MODE_REJECT,
  parameter int CNT_W         = 8
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [N_SRC-1:0]        src_oe,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  input  logic                    bus_hold,
  input  logic                    err_clr,
  output logic [DATA_W-1:0]       bus_out,
  output logic                    bus_valid,
  output logic [SEL_W-1:0]        bus_src,
  output logic                    conflict,
  output logic                    err_sticky,
  output logic [CNT_W-1:0]        conflict_cnt
);

  localparam bit REJECT = (PRIORITY_MODE == BUS_MODE_REJECT);

  logic [SEL_W-1:0]  sel_idx;
  logic              sel_any;
  logic              sel_multi;
  logic [DATA_W-1:0] sel_word;

  onehot_enc_chk #(
    .N     (N_SRC),
    .SEL_W (SEL_W)
  ) u_enc (
    .vec   (src_oe),
    .idx   (sel_idx),
    .any   (sel_any),
    .multi (sel_multi)
  );

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (sel_idx == SEL_W'(i)) sel_word = src_data[i*DATA_W +: DATA_W];
    end
  end

  // Bus registers; with no enable the word and index are kept (bus keeper).
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      bus_out   <= '0;
      bus_valid <= 1'b0;
      bus_src   <= '0;
    end else if (!bus_hold) begin
      if (sel_multi && REJECT) begin
        bus_out   <= '0;
        bus_valid <= 1'b0;
        bus_src   <= '0;
      end else if (sel_any) begin
        bus_out   <= sel_word;
        bus_valid <= 1'b1;
        bus_src   <= sel_idx;
      end else begin
        bus_valid <= 1'b0;
      end
    end
  end

  // Diagnostics keep running through a stall; a conflict beats err_clr.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      conflict     <= 1'b0;
      err_sticky   <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      conflict <= sel_multi;
      if (sel_multi) begin
        err_sticky <= 1'b1;
        if (err_clr)
          conflict_cnt <= CNT_W'(1);
        else if (conflict_cnt != '1)
          conflict_cnt <= conflict_cnt + CNT_W'(1);
      end else if (err_clr) begin
        err_sticky   <= 1'b0;
        conflict_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_bus_mux.sv
// Directed bench: reject-mode, priority-mode and narrow-counter instances share
// one stimulus stream; expected values are hand-derived constants.
module tb_pipelined_bus_mux;

  localparam int N_SRC  = 24;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 5;

  logic                    clk;
  logic                    clr;
  logic [N_SRC-1:0]        src_oe;
  logic [N_SRC*DATA_W-1:0] src_data;
  logic                    bus_hold;
  logic                    err_clr;

  logic [DATA_W-1:0] out0, out1, out2;
  logic              valid0, valid1, valid2;
  logic [SEL_W-1:0]  src0, src1, src2;
  logic              conf0, conf1, conf2;
  logic              err0, err1, err2;
  logic [7:0]        cnt0, cnt1;
  logic [1:0]        cnt2;

  int n_checks = 0;
  int n_errors = 0;

  pipelined_bus_mux #(.N_SRC(N_SRC), .DATA_W(DATA_W), .PRIORITY_MODE(0), .CNT_W(8)) dut0 (
    .clk(clk), .clr(clr), .src_oe(src_oe), .src_data(src_data), .bus_hold(bus_hold),
    .err_clr(err_clr), .bus_out(out0), .bus_valid(valid0), .bus_src(src0),
    .conflict(conf0), .err_sticky(err0), .conflict_cnt(cnt0));

  pipelined_bus_mux #(.N_SRC(N_SRC), .DATA_W(DATA_W), .PRIORITY_MODE(1), .CNT_W(8)) dut1 (
    .clk(clk), .clr(clr), .src_oe(src_oe), .src_data(src_data), .bus_hold(bus_hold),
    .err_clr(err_clr), .bus_out(out1), .bus_valid(valid1), .bus_src(src1),
    .conflict(conf1), .err_sticky(err1), .conflict_cnt(cnt1));

  pipelined_bus_mux #(.N_SRC(N_SRC), .DATA_W(DATA_W), .PRIORITY_MODE(0), .CNT_W(2)) dut2 (
    .clk(clk), .clr(clr), .src_oe(src_oe), .src_data(src_data), .bus_hold(bus_hold),
    .err_clr(err_clr), .bus_out(out2), .bus_valid(valid2), .bus_src(src2),
    .conflict(conf2), .err_sticky(err2), .conflict_cnt(cnt2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word(input int i);
    return 32'hA000_0000 + 32'(i);
  endfunction

  localparam logic [N_SRC-1:0] CONF_PAIR = (24'd1 << 3) | (24'd1 << 20);

  initial begin
    clr      = 1'b0;
    src_oe   = '0;
    bus_hold = 1'b0;
    err_clr  = 1'b0;
    for (int i = 0; i < N_SRC; i++) src_data[i*DATA_W +: DATA_W] = word(i);

    step();
    step();
    chk("rst_out",   out0,        32'h0);
    chk("rst_valid", 32'(valid0), 32'h0);
    chk("rst_src",   32'(src0),   32'h0);
    chk("rst_conf",  32'(conf0),  32'h0);
    chk("rst_err",   32'(err0),   32'h0);
    chk("rst_cnt",   32'(cnt0),   32'h0);

    clr    = 1'b1;
    src_oe = 24'd1 << 5;
    step();
    chk("run_out5", out0,      word(5));
    chk("run_src5", 32'(src0), 32'd5);

    // Asynchronous assert mid-cycle, then release away from the edge.
    #2 clr = 1'b0;
    #1;
    chk("async_out",   out0,        32'h0);
    chk("async_valid", 32'(valid0), 32'h0);
    chk("async_src",   32'(src0),   32'h0);
    #1 clr = 1'b1;
    step();
    chk("rel_out5",   out0,        word(5));
    chk("rel_src5",   32'(src0),   32'd5);
    chk("rel_valid5", 32'(valid0), 32'h1);

    for (int i = 0; i < N_SRC; i++) begin
      src_oe = 24'd1 << i;
      step();
      chk($sformatf("walk_out%0d", i),   out0,        word(i));
      chk($sformatf("walk_src%0d", i),   32'(src0),   32'(i));
      chk($sformatf("walk_valid%0d", i), 32'(valid0), 32'h1);
      chk($sformatf("walk_conf%0d", i),  32'(conf0),  32'h0);
    end

    src_data[9*DATA_W +: DATA_W] = 32'h1234_5678;
    src_oe = 24'd1 << 9;
    step();
    chk("keep_drive", out0, 32'h1234_5678);
    src_oe = '0;
    step();
    chk("keep_out",   out0,        32'h1234_5678);
    chk("keep_valid", 32'(valid0), 32'h0);
    chk("keep_src",   32'(src0),   32'd9);
    src_data[9*DATA_W +: DATA_W] = word(9);

    src_oe = CONF_PAIR;
    step();
    chk("rej_out",   out0,        32'h0);
    chk("rej_valid", 32'(valid0), 32'h0);
    chk("rej_src",   32'(src0),   32'h0);
    chk("rej_conf",  32'(conf0),  32'h1);
    chk("rej_err",   32'(err0),   32'h1);
    chk("rej_cnt",   32'(cnt0),   32'h1);
    chk("pri_out",   out1,        word(3));
    chk("pri_src",   32'(src1),   32'd3);
    chk("pri_valid", 32'(valid1), 32'h1);
    chk("pri_conf",  32'(conf1),  32'h1);

    src_oe = 24'd1 << 4;
    step();
    chk("pulse_end", 32'(conf0), 32'h0);
    chk("err_held",  32'(err0),  32'h1);
    chk("cnt_held",  32'(cnt0),  32'h1);

    src_oe = 24'd1 << 2;
    step();
    chk("hold_pre", out0, word(2));
    bus_hold = 1'b1;
    src_oe   = 24'd1 << 7;
    step();
    chk("hold_out_a", out0,      word(2));
    chk("hold_src_a", 32'(src0), 32'd2);
    step();
    chk("hold_out_b", out0, word(2));
    bus_hold = 1'b0;
    step();
    chk("unhold_out", out0,      word(7));
    chk("unhold_src", 32'(src0), 32'd7);

    bus_hold = 1'b1;
    src_oe   = CONF_PAIR;
    step();
    chk("hconf_out",   out0,        word(7));
    chk("hconf_valid", 32'(valid0), 32'h1);
    chk("hconf_conf",  32'(conf0),  32'h1);
    chk("hconf_cnt",   32'(cnt0),   32'h2);
    chk("hconf_pout",  out1,        word(7));
    bus_hold = 1'b0;

    err_clr = 1'b1;
    src_oe  = 24'd1 << 1;
    step();
    chk("clr_err0", 32'(err0), 32'h0);
    chk("clr_cnt0", 32'(cnt0), 32'h0);
    chk("clr_err2", 32'(err2), 32'h0);
    chk("clr_cnt2", 32'(cnt2), 32'h0);
    err_clr = 1'b0;

    src_oe = CONF_PAIR;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("sat_cnt2_%0d", k), 32'(cnt2), (k > 3) ? 32'd3 : 32'(k));
    end
    chk("nosat_cnt0", 32'(cnt0), 32'd5);

    src_oe = 24'd1 << 1;
    step();
    chk("sat_stay",  32'(cnt2),  32'd3);
    chk("sat_pulse", 32'(conf2), 32'h0);

    err_clr = 1'b1;
    src_oe  = CONF_PAIR;
    step();
    chk("setwin_err2", 32'(err2), 32'h1);
    chk("setwin_cnt2", 32'(cnt2), 32'h1);
    chk("setwin_cnt0", 32'(cnt0), 32'h1);

    src_oe = 24'd1 << 1;
    step();
    chk("clronly_err2", 32'(err2), 32'h0);
    chk("clronly_cnt2", 32'(cnt2), 32'h0);
    chk("clronly_err1", 32'(err1), 32'h0);
    err_clr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
